// File: rtl/key_irq_ctrl_if.sv
// key_irq_ctrl_if: memory-mapped slave bus between the Nios master and
// key_irq_ctrl, including the level interrupt back to the processor.
//
// Handshake: a transfer happens on every clock edge where read or write is
// high; there is no wait state. readdata is registered and is valid the
// cycle after read, holding until the next read. irq is a level signal.
interface key_irq_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: N-channel push-button/switch conditioner for the Nios system.
// Per channel: 2-FF synchroniser, debounce counter, polarity normalisation,
// configurable edge capture and a maskable level interrupt.
//
// Register map (word address):
//   0 DATA    RO   debounced key_state
//   1 IRQMASK RW   one bit per channel
//   2 EDGECAP R/W1C captured edges, a new edge wins over a same-cycle clear
//   3 MODE    RW   two bits per channel: 00 none, 01 rise, 10 fall, 11 both
//
// Optional feature macro: KEY_IRQ_CTRL_LED_MIRROR_EN adds the led_mirror
// output (key_state & ~irqmask, registered).
module key_irq_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [NUM_CH-1:0] key_in,
    key_irq_ctrl_if.slave     avs,
    output logic [NUM_CH-1:0] key_state
`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
    ,
    output logic [NUM_CH-1:0] led_mirror
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] L_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Pin level that means "not pressed"; also the polarity inversion mask.
    localparam logic [NUM_CH-1:0] L_IDLE_PIN = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_CH-1:0]   r_sync1;
    logic [NUM_CH-1:0]   r_sync2;
    logic [NUM_CH-1:0]   r_deb;
    logic [CW-1:0]       r_cnt [NUM_CH];
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_edgecap;
    logic [2*NUM_CH-1:0] r_mode;
    logic [31:0]         r_readdata;
    logic                r_irq;

    logic [NUM_CH-1:0]   w_logical;
    logic [NUM_CH-1:0]   w_deb_nxt;
    logic [CW-1:0]       w_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]   w_rise;
    logic [NUM_CH-1:0]   w_fall;
    logic [NUM_CH-1:0]   w_set;
    logic [NUM_CH-1:0]   w_clr;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic [NUM_CH-1:0]   w_edgecap_nxt;
    logic [31:0]         w_rdata;
    logic                w_wr_mask;
    logic                w_wr_cap;
    logic                w_wr_mode;
    logic                w_unused_wdata;

    // Upper writedata bits beyond the widest register are intentionally ignored.
    assign w_unused_wdata = ^avs.writedata;

    assign w_logical = r_sync2 ^ L_IDLE_PIN;
    assign w_wr_mask = avs.write && (avs.address == 2'd1);
    assign w_wr_cap  = avs.write && (avs.address == 2'd2);
    assign w_wr_mode = avs.write && (avs.address == 2'd3);

    // Two-flop synchroniser; resets to the idle pin level so reset release
    // with keys idle never looks like a press.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= L_IDLE_PIN;
            r_sync2 <= L_IDLE_PIN;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive cycles differing from the current debounced level.
    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_logical[i] == r_deb[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == L_CNT_LAST) begin
                w_deb_nxt[i] = w_logical[i];
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    // Edge qualification and next values of the software-visible registers.
    always_comb begin
        w_rise = w_deb_nxt & ~r_deb;
        w_fall = ~w_deb_nxt & r_deb;
        w_set  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_set[i] = (w_rise[i] & r_mode[2*i]) | (w_fall[i] & r_mode[2*i+1]);
        end
        w_clr         = w_wr_cap ? avs.writedata[NUM_CH-1:0] : '0;
        w_edgecap_nxt = (r_edgecap & ~w_clr) | w_set;
        w_mask_nxt    = w_wr_mask ? avs.writedata[NUM_CH-1:0] : r_mask;
    end

    // Debounce state and counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_deb <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb <= w_deb_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Control registers, edge capture and the registered interrupt line;
    // irq is computed from next-state values so it moves with the registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mask    <= '0;
            r_edgecap <= '0;
            r_mode    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_mask    <= w_mask_nxt;
            r_edgecap <= w_edgecap_nxt;
            if (w_wr_mode) begin
                r_mode <= avs.writedata[2*NUM_CH-1:0];
            end
            r_irq     <= |(w_edgecap_nxt & w_mask_nxt);
        end
    end

    // Read mux over current (pre-write) register values; unused bits read 0.
    always_comb begin
        w_rdata = '0;
        case (avs.address)
            2'd0:    w_rdata[NUM_CH-1:0]   = r_deb;
            2'd1:    w_rdata[NUM_CH-1:0]   = r_mask;
            2'd2:    w_rdata[NUM_CH-1:0]   = r_edgecap;
            2'd3:    w_rdata[2*NUM_CH-1:0] = r_mode;
            default: w_rdata               = '0;
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_readdata <= '0;
        end else if (avs.read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs.readdata = r_readdata;
    assign avs.irq      = r_irq;
    assign key_state    = r_deb;

`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
    logic [NUM_CH-1:0] r_led;

    // LED feedback for keys whose interrupt is masked off.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_led <= '0;
        end else begin
            r_led <= r_deb & ~r_mask;
        end
    end

    assign led_mirror = r_led;
`endif

endmodule

// File: tb/tb_key_irq_ctrl.sv
// tb_key_irq_ctrl: directed bench for key_irq_ctrl with NUM_CH=4,
// DEBOUNCE_CYCLES=16, ACTIVE_LOW=1 (pin low = pressed).
module tb_key_irq_ctrl;

    localparam int NUM_CH = 4;
    localparam int DEB    = 16;

    logic              clk_clk;
    logic              reset_reset_n;
    logic [NUM_CH-1:0] key_in;
    logic [NUM_CH-1:0] key_state;
`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
    logic [NUM_CH-1:0] led_mirror;
`endif

    int n_total;
    int n_bad;

    key_irq_ctrl_if bus_if ();

    key_irq_ctrl #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .key_in        (key_in),
        .avs           (bus_if.slave),
        .key_state     (key_state)
`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
        ,
        .led_mirror    (led_mirror)
`endif
    );

    // Clock
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        tick();
        bus_if.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        tick();
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_reset_n    = 1'b1;
        key_in           = 4'hF;
        bus_if.address   = 2'd0;
        bus_if.read      = 1'b0;
        bus_if.write     = 1'b0;
        bus_if.writedata = '0;
        #3 reset_reset_n = 1'b0;
        #1;
        n_total++;
        if ({key_state, bus_if.irq, bus_if.readdata} !== 37'h0) begin
            n_bad++;
            $display("FAIL reset_initial: key_state=%h irq=%b readdata=%h want 0/0/0", key_state, bus_if.irq, bus_if.readdata);
        end
        repeat (2) tick();
        reset_reset_n = 1'b1;
        tick();
        // Program registers, then reset in the middle of a debounce count.
        bus_write(2'd3, 32'hFF);
        bus_write(2'd1, 32'hF);
        bus_read(2'd3, rd);
        n_total++;
        if (rd !== 32'hFF) begin
            n_bad++;
            $display("FAIL reset_pre_mode: read=%h want %h", rd, 32'hFF);
        end
        key_in = 4'hE;
        repeat (10) tick();
        n_total++;
        if (key_state !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_midcount_state: key_state=%h want 0", key_state);
        end
        reset_reset_n = 1'b0;
        #1;
        n_total++;
        if ({key_state, bus_if.irq, bus_if.readdata} !== 37'h0) begin
            n_bad++;
            $display("FAIL reset_async: key_state=%h irq=%b readdata=%h want 0/0/0", key_state, bus_if.irq, bus_if.readdata);
        end
        key_in = 4'hF;
        tick();
        reset_reset_n = 1'b1;
        tick();
        bus_read(2'd3, rd);
        n_total++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mode_cleared: read=%h want 0", rd);
        end
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mask_cleared: read=%h want 0", rd);
        end
        repeat (25) tick();
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0 || key_state !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_no_edge: edgecap=%h key_state=%h want 0/0", rd, key_state);
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] rd;
        bus_write(2'd3, 32'h01);
        bus_write(2'd1, 32'h1);
        key_in = 4'hE;
        repeat (DEB + 1) tick();
        n_total++;
        if (key_state !== 4'h0 || bus_if.irq !== 1'b0) begin
            n_bad++;
            $display("FAIL press_edge17: key_state=%h irq=%b want 0/0", key_state, bus_if.irq);
        end
        tick();
        n_total++;
        if (key_state !== 4'h1 || bus_if.irq !== 1'b1) begin
            n_bad++;
            $display("FAIL press_edge18: key_state=%h irq=%b want 1/1", key_state, bus_if.irq);
        end
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h1) begin
            n_bad++;
            $display("FAIL press_edgecap: read=%h want 1", rd);
        end
        // Release; rise-only mode must not capture anything new.
        key_in = 4'hF;
        repeat (DEB + 4) tick();
        n_total++;
        if (key_state !== 4'h0) begin
            n_bad++;
            $display("FAIL press_release: key_state=%h want 0", key_state);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        key_in = 4'hE;
        repeat (DEB + 1) tick();
        // The clear lands on the very edge where the new rise is accepted.
        bus_write(2'd2, 32'h1);
        n_total++;
        if (key_state !== 4'h1 || bus_if.irq !== 1'b1) begin
            n_bad++;
            $display("FAIL w1c_race_state: key_state=%h irq=%b want 1/1", key_state, bus_if.irq);
        end
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h1) begin
            n_bad++;
            $display("FAIL w1c_race_keep: read=%h want 1", rd);
        end
        bus_write(2'd2, 32'h1);
        n_total++;
        if (bus_if.irq !== 1'b0) begin
            n_bad++;
            $display("FAIL w1c_irq_drop: irq=%b want 0", bus_if.irq);
        end
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL w1c_clear: read=%h want 0", rd);
        end
    endtask

    task automatic test_bounce();
        for (int ph = 0; ph < 12; ph++) begin
            key_in[1] = (ph % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) begin
                tick();
                n_total++;
                if (key_state[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bounce_stable: phase=%0d key_state[1]=%b want 0", ph, key_state[1]);
                end
            end
        end
        key_in[1] = 1'b0;
        repeat (DEB + 1) tick();
        n_total++;
        if (key_state[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_edge17: key_state[1]=%b want 0", key_state[1]);
        end
        tick();
        n_total++;
        if (key_state !== 4'h3) begin
            n_bad++;
            $display("FAIL bounce_edge18: key_state=%h want 3", key_state);
        end
        key_in[1] = 1'b1;
        repeat (DEB + 4) tick();
    endtask

    task automatic test_mode_both_mask();
        logic [31:0] rd;
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'h30);
        bus_write(2'd2, 32'hF);
        key_in[2] = 1'b0;
        repeat (DEB + 4) tick();
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h4 || key_state !== 4'h5 || bus_if.irq !== 1'b0) begin
            n_bad++;
            $display("FAIL both_press: edgecap=%h key_state=%h irq=%b want 4/5/0", rd, key_state, bus_if.irq);
        end
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL both_clear: edgecap=%h want 0", rd);
        end
        key_in[2] = 1'b1;
        repeat (DEB + 4) tick();
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h4 || bus_if.irq !== 1'b0) begin
            n_bad++;
            $display("FAIL both_release: edgecap=%h irq=%b want 4/0", rd, bus_if.irq);
        end
        bus_write(2'd1, 32'h4);
        n_total++;
        if (bus_if.irq !== 1'b1) begin
            n_bad++;
            $display("FAIL unmask_irq: irq=%b want 1", bus_if.irq);
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        // Read and write to IRQMASK on the same edge returns the old value.
        bus_if.address   = 2'd1;
        bus_if.writedata = 32'hFFFF_FFFF;
        bus_if.read      = 1'b1;
        bus_if.write     = 1'b1;
        tick();
        bus_if.read      = 1'b0;
        bus_if.write     = 1'b0;
        n_total++;
        if (bus_if.readdata !== 32'h4) begin
            n_bad++;
            $display("FAIL rw_same_cycle: readdata=%h want 4", bus_if.readdata);
        end
        bus_if.address = 2'd3;
        repeat (3) tick();
        n_total++;
        if (bus_if.readdata !== 32'h4) begin
            n_bad++;
            $display("FAIL readdata_hold: readdata=%h want 4", bus_if.readdata);
        end
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'hF) begin
            n_bad++;
            $display("FAIL mask_unused_bits: read=%h want f", rd);
        end
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        n_total++;
        if (rd !== 32'h1) begin
            n_bad++;
            $display("FAIL data_ro: read=%h want 1", rd);
        end
        bus_read(2'd3, rd);
        n_total++;
        if (rd !== 32'h30) begin
            n_bad++;
            $display("FAIL mode_read: read=%h want 30", rd);
        end
    endtask

`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
    task automatic test_led_mirror();
        bus_write(2'd1, 32'h0);
        key_in = 4'h7;
        repeat (DEB + 6) tick();
        n_total++;
        if (led_mirror !== 4'h8) begin
            n_bad++;
            $display("FAIL led_on: led_mirror=%h want 8", led_mirror);
        end
        bus_write(2'd1, 32'h8);
        repeat (2) tick();
        n_total++;
        if (led_mirror !== 4'h0) begin
            n_bad++;
            $display("FAIL led_masked: led_mirror=%h want 0", led_mirror);
        end
    endtask
`endif

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_clean_press();
        test_w1c_race();
        test_bounce();
        test_mode_both_mask();
        test_regs();
`ifdef KEY_IRQ_CTRL_LED_MIRROR_EN
        test_led_mirror();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
